instr_fetch: RTL and testbench

Instruction-fetch stage between the program counter and decode. Takes the next-PC redirect from the PC/branch logic, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PC in a small prefetch FIFO. Decode drains the FIFO with a valid/ready handshake, so memory wait states and decode stalls are decoupled.

---
 rtl/ifetch_pkg.sv | 29 ++
 rtl/ifetch_fifo.sv | 74 +++++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e   : fetch FSM states (REQ, WAIT, DROP)
//   IFETCH_RESET_PC : default first fetch address after reset
//   fetch_entry_t   : one prefetch FIFO entry {pc, inst}
//   word_align()    : clears the byte-offset bits of an address
// Optional feature macro used by instr_fetch: IFETCH_BYPASS_EN
// ---------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// Prefetch FIFO of DEPTH fetch_entry_t entries between memory and decode.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   flush         : drops all entries; overrides push and pop this cycle
//   push          : write push_entry at the tail (caller guarantees space)
//   push_entry    : {pc, inst} to store
//   pop           : remove the head entry (ignored when empty)
//   count         : number of valid entries, 0..DEPTH
//   head          : head entry, read straight from storage registers
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    // Head comes directly from storage, so nothing from decode's ready
    // reaches the head outputs combinationally.
    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage: issues word reads to instruction memory with a
// req/gnt/rvalid handshake (one request outstanding at most), buffers the
// returned words with their PC in a prefetch FIFO and hands them to decode
// with a valid/ready handshake. A redirect restarts fetch at a new address.
// Ports:
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc      : restart fetch at redirect_pc (low bits cleared)
//   imem_req, imem_addr        : read request and its word address
//   imem_gnt                   : memory accepts the request this cycle
//   imem_rvalid, imem_rdata    : in-order read response
//   inst_valid, inst, inst_pc  : FIFO head presented to decode
//   inst_pcplus4               : inst_pc + 4 (wraps mod 2^32)
//   inst_ready                 : decode consumes the head this cycle
// Configuration macro: IFETCH_BYPASS_EN -- when defined, a response arriving
// while the FIFO is empty is presented to decode in the same cycle.
// ---------------------------------------------------------------------------
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pcplus4,
    input  logic        inst_ready
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    fetch_state_e   state;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;
    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           head_valid;
    logic           fifo_full;
    logic           granted;
    logic           response;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           outstanding_after;

    assign head_valid = (count != '0);
    assign fifo_full  = (count == FULL_COUNT);

    // A request is only raised with a free slot, so the eventual push can
    // never overflow. Reset masks the request while it is held.
    assign imem_req  = !reset && (state == REQ) && !fifo_full;
    assign imem_addr = fetch_pc;
    assign granted   = imem_req && imem_gnt;
    assign response  = (state == WAIT) && imem_rvalid;

`ifdef IFETCH_BYPASS_EN
    // Empty FIFO plus a live response: hand the word to decode directly.
    assign bypass = !head_valid && response && !redirect;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes immediately is never stored.
    assign push       = response && !redirect && !(bypass && inst_ready);
    assign pop        = head_valid && inst_ready;
    assign push_entry = '{pc: req_pc, inst: imem_rdata};

    assign inst_valid   = head_valid || bypass;
    assign inst         = bypass ? imem_rdata : head.inst;
    assign inst_pc      = bypass ? req_pc : head.pc;
    assign inst_pcplus4 = inst_pc + 32'd4;

    // On a redirect, a request still in flight must have its response
    // thrown away, which is what DROP is for.
    assign outstanding_after = granted
                            || ((state == WAIT) && !imem_rvalid)
                            || ((state == DROP) && !imem_rvalid);

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    // Fetch FSM: redirect outranks every other event in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
            state    <= outstanding_after ? DROP : REQ;
        end else begin
            case (state)
                REQ: begin
                    if (granted) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch (default build, bypass disabled). A small
// memory model grants requests when enabled and returns addr ^ 32'hA5A5_0000
// one cycle after the grant, unless responses are being held back.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic [31:0] instPcplus4;
    logic        instReady;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expectedPc;
    bit          memGrant   = 0;
    bit          stallResp  = 0;
    bit          pending    = 0;
    logic [31:0] pendAddr   = '0;

    instr_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirectPc),
        .imem_req     (imemReq),
        .imem_addr    (imemAddr),
        .imem_gnt     (imemGnt),
        .imem_rvalid  (imemRvalid),
        .imem_rdata   (imemRdata),
        .inst_valid   (instValid),
        .inst         (inst),
        .inst_pc      (instPc),
        .inst_pcplus4 (instPcplus4),
        .inst_ready   (instReady)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case a stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rst, input logic redir,
                                 input logic [31:0] rpc, input logic rdy);
        reset      = rst;
        redirect   = redir;
        redirectPc = rpc;
        instReady  = rdy;
        #1;
    endtask

    // One clock cycle: drive the memory handshake, then advance the model.
    task automatic stepClock();
        logic        granted;
        logic        delivered;
        logic [31:0] grantAddr;
        imemRvalid = pending && !stallResp;
        imemRdata  = imemRvalid ? (pendAddr ^ KEY) : 32'h0;
        imemGnt    = memGrant && imemReq;
        granted    = imemGnt;
        delivered  = imemRvalid;
        grantAddr  = imemAddr;
        @(posedge clock);
        if (delivered) pending = 0;
        if (granted) begin
            pending  = 1;
            pendAddr = grantAddr;
        end
        @(negedge clock);
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
    endtask

    // Consume n instructions in program order starting at expectedPc.
    task automatic collect(input int n, input int budget);
        int got = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (instValid && instReady) begin
                checkOutput("inst_pc", instPc, expectedPc);
                checkOutput("inst", inst, expectedPc ^ KEY);
                checkOutput("inst_pcplus4", instPcplus4, expectedPc + 32'd4);
                expectedPc = expectedPc + 32'd4;
                got++;
            end
            stepClock();
            if (got == n) break;
        end
        checkOutput("deliveries", 32'(got), 32'(n));
    endtask

    task automatic checkResetValues();
        checkOutput("rst_imem_req", 32'(imemReq), 32'd0);
        checkOutput("rst_imem_addr", imemAddr, 32'h0000_0000);
        checkOutput("rst_inst_valid", 32'(instValid), 32'd0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", instPc, 32'h0);
        checkOutput("rst_inst_pcplus4", instPcplus4, 32'h4);
    endtask

    initial begin
        int drained;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        reset      = 1'b1;
        redirect   = 1'b0;
        redirectPc = '0;
        instReady  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;

        $display("[TB] reset state");
        checkResetValues();

        $display("[TB] streaming from reset");
        memGrant = 1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("first_req", 32'(imemReq), 32'd1);
        checkOutput("first_addr", imemAddr, 32'h0000_0000);
        expectedPc = 32'h0;
        collect(4, 20);

        $display("[TB] decode stall fills FIFO");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) stepClock();
        checkOutput("full_req_low", 32'(imemReq), 32'd0);
        checkOutput("full_valid", 32'(instValid), 32'd1);
        checkOutput("full_head_pc", instPc, expectedPc);
        memGrant = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        drained = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (instValid && instReady) begin
                checkOutput("drain_pc", instPc, expectedPc);
                checkOutput("drain_inst", inst, expectedPc ^ KEY);
                expectedPc = expectedPc + 32'd4;
                drained++;
            end
            stepClock();
        end
        checkOutput("drained_count", 32'(drained), 32'd2);

        $display("[TB] redirect while waiting");
        memGrant  = 1;
        stallResp = 1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("pre_redir_req", 32'(imemReq), 32'd1);
        checkOutput("pre_redir_addr", imemAddr, expectedPc);
        stepClock();
        applyStimulus(1'b0, 1'b1, 32'h0000_1003, 1'b1);
        checkOutput("wait_req_low", 32'(imemReq), 32'd0);
        stepClock();
        stallResp = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drop_req_low", 32'(imemReq), 32'd0);
        checkOutput("drop_empty", 32'(instValid), 32'd0);
        stepClock();
        #1;
        checkOutput("after_drop_req", 32'(imemReq), 32'd1);
        checkOutput("after_drop_addr", imemAddr, 32'h0000_1000);
        checkOutput("after_drop_empty", 32'(instValid), 32'd0);
        expectedPc = 32'h0000_1000;
        collect(2, 12);

        $display("[TB] redirect with response and pop, wrap target");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) stepClock();
        checkOutput("refill_req_low", 32'(imemReq), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("one_free_req", 32'(imemReq), 32'd1);
        stepClock();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("pre_flush_valid", 32'(instValid), 32'd1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("flush_empty", 32'(instValid), 32'd0);
        checkOutput("flush_req", 32'(imemReq), 32'd1);
        checkOutput("flush_addr", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        expectedPc = 32'hFFFF_FFFC;
        collect(2, 12);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) stepClock();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_req", 32'(imemReq), 32'd1);
        stepClock();
        stallResp = 1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_valid", 32'(instValid), 32'd1);
        stepClock();
        #1;
        checkResetValues();
        memGrant  = 0;
        stallResp = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_req", 32'(imemReq), 32'd1);
        checkOutput("post_rst_addr", imemAddr, 32'h0000_0000);
        stepClock();
        #1;
        checkOutput("stale_ignored", 32'(instValid), 32'd0);
        checkOutput("stale_addr", imemAddr, 32'h0000_0000);
        memGrant   = 1;
        expectedPc = 32'h0;
        collect(3, 16);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
